// File: rtl/shared_add_arbiter_if.sv
// ============================================================================
// Module : shared_add_arbiter_if
// Brief  : Request/response channels of both cores toward the shared adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface shared_add_arbiter_if #(
  parameter int OP_W = 8
);
  logic            req0_valid;
  logic            req0_ready;
  logic [OP_W-1:0] req0_a;
  logic [OP_W-1:0] req0_b;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [OP_W:0]   rsp0_sum;

  logic            req1_valid;
  logic            req1_ready;
  logic [OP_W-1:0] req1_a;
  logic [OP_W-1:0] req1_b;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [OP_W:0]   rsp1_sum;

  modport master (
    output req0_valid, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_sum,
    input  req1_ready, rsp1_valid, rsp1_sum
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_sum,
    output req1_ready, rsp1_valid, rsp1_sum
  );
endinterface

`default_nettype wire

// File: rtl/shared_add_arbiter.sv
// ============================================================================
// Module : shared_add_arbiter
// Brief  : Two-core arbiter/sequencer time-sharing one 8-bit carry-lookahead
//          adder. Define SHARED_ADD_RR_EN for round-robin, else fixed priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shared_add_arbiter #(
  parameter int OP_W = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  shared_add_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int NBLK = OP_W / 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OP_W-1:0] r_op_a;
  logic [OP_W-1:0] r_op_b;
  logic [OP_W:0]   r_result;
  logic            r_grant;
  logic            w_win;
  logic            w_accept;
  logic            w_rsp_fire;

  // Shared adder: 4-bit lookahead blocks, block carries chained.
  logic [OP_W-1:0] w_g;
  logic [OP_W-1:0] w_p;
  logic [OP_W:0]   w_c;
  logic [OP_W:0]   w_sum;

  assign w_g    = r_op_a & r_op_b;
  assign w_p    = r_op_a ^ r_op_b;
  assign w_c[0] = 1'b0;

  generate
    for (genvar blk = 0; blk < NBLK; blk++) begin : g_cla_blk
      localparam int B = blk * 4;
      assign w_c[B+1] = w_g[B] | (w_p[B] & w_c[B]);
      assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                      | (w_p[B+1] & w_p[B] & w_c[B]);
      assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                      | (w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
      assign w_c[B+4] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                      | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    end
  endgenerate

  assign w_sum = {w_c[OP_W], w_p ^ w_c[OP_W-1:0]};

`ifdef SHARED_ADD_RR_EN
  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_rsp_fire) begin
      r_ptr <= ~r_grant;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_win          = ~bus.req0_valid;
`ifdef SHARED_ADD_RR_EN
    if (bus.req0_valid && bus.req1_valid) begin
      w_win = r_ptr;
    end
`endif
    // Ready is gated by rst so it stays low throughout reset assertion.
    w_accept       = (r_state == ST_IDLE) && !rst
                   && (bus.req0_valid || bus.req1_valid);
    w_rsp_fire     = (r_state == ST_RESP)
                   && (r_grant ? bus.rsp1_ready : bus.rsp0_ready);
    bus.req0_ready = w_accept && !w_win;
    bus.req1_ready = w_accept && w_win;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
      ST_EXEC:                 w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_fire) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_grant  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a  <= w_win ? bus.req1_a : bus.req0_a;
        r_op_b  <= w_win ? bus.req1_b : bus.req0_b;
        r_grant <= w_win;
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_sum;
      end
    end
  end

  assign bus.rsp0_valid = (r_state == ST_RESP) && !r_grant;
  assign bus.rsp1_valid = (r_state == ST_RESP) && r_grant;
  assign bus.rsp0_sum   = r_result;
  assign bus.rsp1_sum   = r_result;
  assign busy           = (r_state != ST_IDLE);
  assign grant_id       = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_shared_add_arbiter.sv
// ============================================================================
// Module : tb_shared_add_arbiter
// Brief  : Self-checking bench for shared_add_arbiter (directed + random ops).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shared_add_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic grant_id;
  int   checks    = 0;
  int   failures  = 0;
  int   model_ptr = 0;

  shared_add_arbiter_if #(.OP_W(8)) bus();

  shared_add_arbiter #(.OP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference arbitration rule: lone requester wins; ties go to the preferred core.
  function automatic int exp_winner(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef SHARED_ADD_RR_EN
      return model_ptr;
`else
      return 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h22;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h33; bus.req1_b = 8'h44;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_valid: got %b%b want 00", bus.rsp0_valid, bus.rsp1_valid);
    end
    checks++;
    if (bus.rsp0_sum !== 9'h000 || bus.rsp1_sum !== 9'h000) begin
      failures++;
      $display("FAIL reset_sum: got %h/%h want 000", bus.rsp0_sum, bus.rsp1_sum);
    end
    checks++;
    if (busy !== 1'b0 || grant_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_grant: got busy=%b grant=%b want 0/0", busy, grant_id);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    #1;
  endtask

  task automatic test_single_core0();
    @(negedge clk);
    bus.req0_a = 8'h12; bus.req0_b = 8'h34; bus.req0_valid = 1'b1;
    bus.rsp0_ready = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_exec: got busy=%b v0=%b v1=%b want 1/0/0",
               busy, bus.rsp0_valid, bus.rsp1_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_sum !== 9'h046 || bus.rsp1_valid !== 1'b0
        || grant_id !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got v0=%b sum=%h v1=%b grant=%b want 1/046/0/0",
               bus.rsp0_valid, bus.rsp0_sum, bus.rsp1_valid, grant_id);
    end
    model_ptr = 1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.rsp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got busy=%b v0=%b want 0/0", busy, bus.rsp0_valid);
    end
  endtask

  task automatic test_carry_core1();
    logic [7:0] av [2];
    logic [7:0] bv [2];
    av[0] = 8'hFF; bv[0] = 8'h01;
    av[1] = 8'h80; bv[1] = 8'h80;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.req1_a = av[i]; bus.req1_b = bv[i]; bus.req1_valid = 1'b1;
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
        failures++;
        $display("FAIL carry_ready[%0d]: got %b%b want 01", i, bus.req0_ready, bus.req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_sum !== 9'h100 || grant_id !== 1'b1
          || bus.rsp0_valid !== 1'b0) begin
        failures++;
        $display("FAIL carry_rsp[%0d]: got v1=%b sum=%h grant=%b v0=%b want 1/100/1/0",
                 i, bus.rsp1_valid, bus.rsp1_sum, grant_id, bus.rsp0_valid);
      end
      model_ptr = 0;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_tie();
    int   w;
    logic saw_r1 = 1'b0;
    logic exp_saw = 1'b0;
    bus.req0_a = 8'h21; bus.req0_b = 8'h01;
    bus.req1_a = 8'h40; bus.req1_b = 8'h02;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      w = exp_winner(1'b1, 1'b1);
      if (w == 1) exp_saw = 1'b1;
      if (bus.req1_ready === 1'b1) saw_r1 = 1'b1;
      checks++;
      if (bus.req0_ready !== (w == 0) || bus.req1_ready !== (w == 1)) begin
        failures++;
        $display("FAIL tie_ready[%0d]: got %b%b want winner %0d",
                 i, bus.req0_ready, bus.req1_ready, w);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      if (bus.req1_ready === 1'b1) saw_r1 = 1'b1;
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL tie_exec_ready[%0d]: got %b%b want 00", i, bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (grant_id !== w[0] || (w == 0 ? bus.rsp0_sum : bus.rsp1_sum) !== (w == 0 ? 9'h022 : 9'h042)
          || bus.rsp0_valid !== (w == 0) || bus.rsp1_valid !== (w == 1)) begin
        failures++;
        $display("FAIL tie_rsp[%0d]: got grant=%b sum=%h v=%b%b want grant=%0d",
                 i, grant_id, bus.rsp0_sum, bus.rsp0_valid, bus.rsp1_valid, w);
      end
      model_ptr = 1 - w;
      @(negedge clk);
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checks++;
    if (saw_r1 !== exp_saw) begin
      failures++;
      $display("FAIL tie_req1_seen: got %b want %b", saw_r1, exp_saw);
    end
  endtask

  task automatic test_backpressure();
    bus.req0_a = 8'h3C; bus.req0_b = 8'h0F; bus.req0_valid = 1'b1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept0: got %b want 1", bus.req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_a = 8'h05; bus.req1_b = 8'h06; bus.req1_valid = 1'b1;
    @(negedge clk);
    #1;
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_sum !== 9'h04B || bus.req1_ready !== 1'b0
          || bus.rsp1_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v0=%b sum=%h r1=%b v1=%b want 1/04B/0/0",
                 s, bus.rsp0_valid, bus.rsp0_sum, bus.req1_ready, bus.rsp1_valid);
      end
      if (s < 4) begin
        @(negedge clk);
        #1;
      end
    end
    bus.rsp0_ready = 1'b1;
    model_ptr = 1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1 || bus.rsp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_accept: got r1=%b v0=%b want 1/0", bus.req1_ready, bus.rsp0_valid);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_sum !== 9'h00B) begin
      failures++;
      $display("FAIL bp_core1_rsp: got v1=%b sum=%h want 1/00B", bus.rsp1_valid, bus.rsp1_sum);
    end
    model_ptr = 0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset_exec();
    bus.rsp0_ready = 1'b1;
    bus.req0_a = 8'h55; bus.req0_b = 8'h66; bus.req0_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstexec_now: got busy=%b v=%b%b want 0/00", busy, bus.rsp0_valid, bus.rsp1_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp0_sum !== 9'h000) begin
      failures++;
      $display("FAIL rstexec_hold: got v0=%b sum=%h want 0/000", bus.rsp0_valid, bus.rsp0_sum);
    end
    rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    bus.req0_a = 8'h01; bus.req0_b = 8'h02; bus.req0_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_sum !== 9'h003) begin
      failures++;
      $display("FAIL rstexec_reissue: got v0=%b sum=%h want 1/003", bus.rsp0_valid, bus.rsp0_sum);
    end
    model_ptr = 1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_random();
    logic       pend [2];
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    int         w;
    int         c;
    int         stall;
    int         exp_sum;
    logic [8:0] got;
    pend[0] = 1'b0; pend[1] = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1; pa[k] = 8'($urandom); pb[k] = 8'($urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin
        c = $urandom_range(0, 1);
        pend[c] = 1'b1; pa[c] = 8'($urandom); pb[c] = 8'($urandom);
      end
      bus.req0_valid = pend[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0];
      bus.req1_valid = pend[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1];
      #1;
      w = exp_winner(pend[0], pend[1]);
      checks++;
      if (bus.req0_ready !== (w == 0) || bus.req1_ready !== (w == 1)) begin
        failures++;
        $display("FAIL rand_ready[%0d]: got %b%b want winner %0d (v=%b%b)",
                 n, bus.req0_ready, bus.req1_ready, w, pend[0], pend[1]);
      end
      @(posedge clk);
      exp_sum = int'(pa[w]) + int'(pb[w]);
      pend[w] = 1'b0;
      @(negedge clk);
      if (w == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
      stall = $urandom_range(0, 3);
      @(negedge clk);
      #1;
      for (int s = 0; s <= stall; s++) begin
        got = (w == 0) ? bus.rsp0_sum : bus.rsp1_sum;
        checks++;
        if (got !== 9'(exp_sum) || bus.rsp0_valid !== (w == 0) || bus.rsp1_valid !== (w == 1)
            || grant_id !== w[0] || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
          failures++;
          $display("FAIL rand_rsp[%0d.%0d]: got sum=%h v=%b%b grant=%b rdy=%b%b want sum=%h owner=%0d",
                   n, s, got, bus.rsp0_valid, bus.rsp1_valid, grant_id,
                   bus.req0_ready, bus.req1_ready, 9'(exp_sum), w);
        end
        if (s < stall) begin
          @(negedge clk);
          #1;
        end
      end
      if (w == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
      @(posedge clk);
      model_ptr = 1 - w;
      @(negedge clk);
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_core0();
    test_carry_core1();
    test_tie();
    test_backpressure();
    test_reset_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
